sobel_scan_ctrl: RTL

//  Frame-scan sequencer for the Sobel edge-detect datapath. On a start pulse it

---
 rtl/sobel_scan_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sobel_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_scan_ctrl
//   Frame-scan sequencer for the Sobel edge-detect datapath. A start pulse
//   captures the frame size, then the block raster-reads the source image
//   BRAM, tags every returned pixel with row/column/border information for the
//   Sobel core, and writes the core results into the result BRAM after a fixed
//   core latency. Status outputs report idle/read/write/done.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   i_run              start pulse, sampled only in IDLE
//   i_width, i_height  frame size in pixels, captured when i_run is accepted
//   o_idle, o_read     state flags (IDLE, READ)
//   o_write            high in every cycle that writes the result BRAM
//   o_done             one-cycle end-of-frame pulse
//   o_rd_ce, o_rd_addr source BRAM chip enable / address
//   o_pix_vld          source BRAM q valid (o_rd_ce delayed one cycle)
//   o_col, o_row       coordinates of the pixel on q, valid with o_pix_vld
//   o_border           pixel lies on the frame edge, valid with o_pix_vld
//   o_wr_ce, o_wr_we   result BRAM chip enable / write enable (identical)
//   o_wr_addr          result BRAM address
//   o_state            current FSM state, debug visibility only
//
// Handshake: there is no back-pressure. i_run is a single-cycle request that
// is accepted only when o_idle=1; once accepted the frame runs to o_done
// without stalls, and the BRAM ports are simple enable/address strobes.
// ---------------------------------------------------------------------------
module sobel_scan_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_run,
  input  logic [ADDR_WIDTH-1:0] i_width,
  input  logic [ADDR_WIDTH-1:0] i_height,
  output logic                  o_idle,
  output logic                  o_read,
  output logic                  o_write,
  output logic                  o_done,
  output logic                  o_rd_ce,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_pix_vld,
  output logic [ADDR_WIDTH-1:0] o_col,
  output logic [ADDR_WIDTH-1:0] o_row,
  output logic                  o_border,
  output logic                  o_wr_ce,
  output logic                  o_wr_we,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [1:0]            o_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] width_q;
  logic [ADDR_WIDTH-1:0] height_q;
  logic [ADDR_WIDTH-1:0] total_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] rd_col;
  logic [ADDR_WIDTH-1:0] rd_row;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [PIPE_LAT-1:0]   vld_sr;

  logic [ADDR_WIDTH-1:0] total_next;
  logic                  rd_active;
  logic                  rd_last;
  logic                  col_last;
  logic                  rd_border;
  logic                  wr_last;

  // Product deliberately truncated to the address width.
  assign total_next = i_width * i_height;

  assign rd_active = (state == S_READ);
  assign rd_last   = (rd_addr == total_q - ONE);
  assign col_last  = (rd_col == width_q - ONE);
  assign rd_border = (rd_row == '0) || (rd_row == height_q - ONE) ||
                     (rd_col == '0) || col_last;
  assign wr_last   = o_wr_we && (wr_addr == total_q - ONE);

  assign o_idle    = (state == S_IDLE);
  assign o_read    = rd_active;
  assign o_done    = (state == S_DONE);
  assign o_rd_ce   = rd_active;
  assign o_rd_addr = rd_active ? rd_addr : '0;
  assign o_wr_we   = vld_sr[PIPE_LAT-1];
  assign o_wr_ce   = o_wr_we;
  assign o_write   = o_wr_we;
  assign o_wr_addr = wr_addr;
  assign o_state   = state;

  // Frame FSM and read-side counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      width_q  <= '0;
      height_q <= '0;
      total_q  <= '0;
      rd_addr  <= '0;
      rd_col   <= '0;
      rd_row   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_run) begin
            width_q  <= i_width;
            height_q <= i_height;
            total_q  <= total_next;
            rd_addr  <= '0;
            rd_col   <= '0;
            rd_row   <= '0;
            // An empty frame (including a product that truncates to 0)
            // skips straight to the done pulse.
            if (i_width == '0 || i_height == '0 || total_next == '0)
              state <= S_DONE;
            else
              state <= S_READ;
          end
        end
        S_READ: begin
          if (rd_last) begin
            state <= S_DRAIN;
          end else begin
            rd_addr <= rd_addr + ONE;
          end
          if (col_last) begin
            rd_col <= '0;
            rd_row <= rd_row + ONE;
          end else begin
            rd_col <= rd_col + ONE;
          end
        end
        S_DRAIN: begin
          if (wr_last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pixel tag stage: coordinates of the address read last cycle line up
  // with the BRAM q data this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pix_vld <= 1'b0;
      o_col     <= '0;
      o_row     <= '0;
      o_border  <= 1'b0;
    end else begin
      o_pix_vld <= rd_active;
      if (rd_active) begin
        o_col    <= rd_col;
        o_row    <= rd_row;
        o_border <= rd_border;
      end
    end
  end

  // Write side: pixel-valid delayed by the core latency becomes the write
  // strobe; the write address steps once per completed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr  <= '0;
      wr_addr <= '0;
    end else begin
      vld_sr[0] <= o_pix_vld;
      for (int i = 1; i < PIPE_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      if (state == S_IDLE && i_run)
        wr_addr <= '0;
      else if (o_wr_we)
        wr_addr <= wr_addr + ONE;
    end
  end

endmodule
